adder_display: RTL and testbench
================================

# adder_display

Downstream consumer of the 8-bit adder. It takes the adder's `result` and `carry` as a 9-bit unsigned sum from 0 to 511 and converts it to three BCD digits with a sequential double-dabble engine. It then drives the Nexys 4 eight-digit seven-segment display with a time-multiplexed scan. The adder outputs connect directly to this block, and the display outputs go to the board pins.

## Interface
- `REFRESH_DIV`, default 100000: `clk` cycles per digit slot. Gives 1 kHz per digit at 100 MHz. Legal range is ≥ 2.
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `result`  in  8  adder sum bits, unsigned.
- `carry`  in  1  adder carry-out; forms bit 8 of the value.
- `anode`  out  8  digit enables, active-low; bit 0 is the rightmost digit.
- `seg`  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- `dp`  out  1  decimal point, active-low; held 1 (off) at all times.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- `value = {carry, result}`, 9 bits.
- Conversion FSM states:
  - **IDLE**: if `value != last`, capture `value` into the shift register and into `last`, clear the BCD accumulator (12 bits), set `cnt` to 0, and go to **SHIFT**.
  - **SHIFT**: once per cycle, add 3 to every BCD nibble that is ≥ 5, then shift {bcd, shreg} left by 1. When `cnt` reaches 8 (the 9th shift), go to **LOAD**.
  - **LOAD**: copy the BCD result to the digit registers `d2:d1:d0` (hundreds:tens:ones), then go to **IDLE**.
- `busy` is 1 in SHIFT and LOAD and 0 in IDLE.
- Input changes during SHIFT or LOAD are ignored. IDLE re-compares afterwards, so the last stable value is always displayed eventually.
- Scan:
  - The refresh counter runs from 0 to REFRESH_DIV−1 and wraps.
  - On each wrap, digit select advances 0→1→2→0.
  - Only anodes 0–2 are ever driven; anodes 7..3 are held high.
- Leading-zero blanking:
  - The hundreds digit is blanked when `d2 == 0`.
  - The tens digit is blanked when `d2 == 0 && d1 == 0`.
  - The ones digit is never blanked.
  - In a blanked slot the anode stays high, and `seg` is a don't-care that is driven 7'h7F.
- Segment codes (active-low {g..a}):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- `anode` and `seg` are registered. They change on the same edge, so there is no ghosting skew between them.

## Timing
- Reset values (asserted asynchronously):
  - State IDLE, `last` 0, digits 0, refresh counter 0, select 0.
  - `busy` = 0, `anode` = 8'b11111110, `seg` = 7'b1000000, `dp` = 1.
- Conversion latency:
  - Edge E (in IDLE) captures the new value.
  - `busy` is high from E to E+10. That covers 9 SHIFT edges and 1 LOAD edge.
  - The digit registers update at edge E+10.
  - The displayed slot reflects the new digits from the next register update of `seg`/`anode`, at most 1 cycle later.
- Back-to-back changes: the earliest possible next capture is edge E+11.
- Reset asserted mid-conversion aborts immediately. The display shows "0", and after release a nonzero input is re-converted.
- Digit period is REFRESH_DIV cycles. The full frame is 3 × REFRESH_DIV cycles.

## Test plan
- **Reset:** assert `rst` with inputs 0 → `anode` = FE, `seg` = 1000000, `busy` = 0. Hold inputs at 0 for 20 cycles → `busy` stays 0.
- **Small sum:** `result` = 8'h14, `carry` = 0 (10+10) → `busy` is high for exactly 10 cycles, then digits are 0,2,0. Anode 2 is never low; slot 1 shows 0100100 and slot 0 shows 1000000.
- **Max sum:** `result` = 8'hFE, `carry` = 1 (255+255) → digits 5,1,0. Slots 2/1/0 show 0010010 / 1111001 / 1000000.
- **Mid-conversion change:** set 8'h14, then at busy cycle 4 change to 8'h09 → 20 is loaded first, then 9 is converted. The final display is the single digit 0010000 with anodes 1 and 2 high.
- **Reset mid-conversion:** pulse `rst` at busy cycle 5 with input 8'h63 → the display is immediately "0". After release, 99 is converted and shown in slots 1 and 0 as 0010000 and 0010000.
- **Scan:** with REFRESH_DIV = 4 and value 123, `anode` cycles FE→FD→FB, changing every 4 cycles, with matching `seg` codes. `dp` is 1 throughout.

Source files
------------

// File: rtl/adder_display.sv
// rtl/adder_display.sv - 9-bit adder sum to 3-digit BCD with multiplexed 7-segment scan
module adder_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result,
  input  logic       carry,
  output logic [7:0] anode,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t        state, state_nxt;
  logic [8:0]    value;
  logic [8:0]    last, last_nxt;
  logic [8:0]    shreg, shreg_nxt;
  logic [11:0]   bcd, bcd_nxt, adj;
  logic [20:0]   shifted;
  logic [3:0]    cnt, cnt_nxt;
  logic          load;
  logic [3:0]    d2, d1, d0;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    sel;
  logic [3:0]    digit;
  logic          blank;
  logic [7:0]    anode_nxt;
  logic [6:0]    seg_nxt;

  assign value = {carry, result};
  assign dp    = 1'b1;
  assign busy  = (state != IDLE);

  // Double-dabble step: correct each nibble before the shift so it carries in decimal.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    shifted = {adj, shreg} << 1;
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    shreg_nxt = shreg;
    bcd_nxt   = bcd;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (value != last) begin
          shreg_nxt = value;
          last_nxt  = value;
          bcd_nxt   = 12'd0;
          cnt_nxt   = 4'd0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_nxt, shreg_nxt} = shifted;
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'd8) state_nxt = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 9'd0;
      shreg <= 9'd0;
      bcd   <= 12'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      shreg <= shreg_nxt;
      bcd   <= bcd_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d2 <= 4'd0;
      d1 <= 4'd0;
      d0 <= 4'd0;
    end else if (load) begin
      d2 <= bcd[11:8];
      d1 <= bcd[7:4];
      d0 <= bcd[3:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      sel         <= 2'd0;
    end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      sel         <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // Leading zeros are blanked by leaving the anode off; seg is parked all-off.
  always_comb begin
    digit = d0;
    blank = 1'b0;
    case (sel)
      2'd1: begin
        digit = d1;
        blank = (d2 == 4'd0) && (d1 == 4'd0);
      end
      2'd2: begin
        digit = d2;
        blank = (d2 == 4'd0);
      end
      default: begin
        digit = d0;
        blank = 1'b0;
      end
    endcase
    anode_nxt = blank ? 8'hFF : ~(8'd1 << sel);
    seg_nxt   = blank ? 7'h7F : seg_code(digit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode <= 8'b11111110;
      seg   <= 7'b1000000;
    end else begin
      anode <= anode_nxt;
      seg   <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_adder_display.sv
// tb/tb_adder_display.sv - randomized, model-checked bench for adder_display
module tb_adder_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] result = 8'd0;
  logic       carry = 1'b0;
  logic [7:0] anode;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  adder_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .result(result), .carry(carry),
    .anode(anode), .seg(seg), .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit is_blank(input int s, input int v);
    return (s == 2 && v < 100) || (s == 1 && v < 10);
  endfunction

  function automatic logic [7:0] exp_anode(input int s, input int v);
    if (is_blank(s, v)) return 8'hFF;
    case (s)
      0: return 8'hFE;
      1: return 8'hFD;
      default: return 8'hFB;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int s, input int v);
    int d;
    if (is_blank(s, v)) return 7'h7F;
    case (s)
      0: d = v % 10;
      1: d = (v / 10) % 10;
      default: d = v / 100;
    endcase
    return seg_of(d);
  endfunction

  // Behavioural model: a conversion is a 10-cycle busy window ending with the
  // displayed number becoming the captured value; scan is a slot counter.
  int         m_last, m_conv, m_busy, m_dig, m_cnt, m_sel;
  logic [7:0] m_anode;
  logic [6:0] m_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last  <= 0;
      m_conv  <= 0;
      m_busy  <= 0;
      m_dig   <= 0;
      m_cnt   <= 0;
      m_sel   <= 0;
      m_anode <= 8'hFE;
      m_seg   <= 7'b1000000;
    end else begin
      if (m_busy == 0) begin
        if (int'({carry, result}) != m_last) begin
          m_last <= int'({carry, result});
          m_conv <= int'({carry, result});
          m_busy <= 10;
        end
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) m_dig <= m_conv;
      end
      if (m_cnt == DIV - 1) begin
        m_cnt <= 0;
        m_sel <= (m_sel + 1) % 3;
      end else begin
        m_cnt <= m_cnt + 1;
      end
      m_anode <= exp_anode(m_sel, m_dig);
      m_seg   <= exp_seg(m_sel, m_dig);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (anode !== m_anode || seg !== m_seg || busy !== (m_busy != 0) || dp !== 1'b1) begin
        errors++;
        $display("FAIL model t=%0t anode=%h/%h seg=%b/%b busy=%b/%b dp=%b/1",
                 $time, anode, m_anode, seg, m_seg, busy, (m_busy != 0), dp);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  task automatic set_val(input int v);
    {carry, result} = 9'(v);
  endtask

  // Observe 16 cycles (over one full frame) and check what each slot showed.
  task automatic check_frame(input string nm, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input bit b1, input bit b2);
    bit seen0 = 0, seen1 = 0, seen2 = 0;
    logic [6:0] s0 = 7'h0, s1 = 7'h0, s2 = 7'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (anode == 8'hFE) begin seen0 = 1; s0 = seg; end
      if (anode == 8'hFD) begin seen1 = 1; s1 = seg; end
      if (anode == 8'hFB) begin seen2 = 1; s2 = seg; end
    end
    check({nm, "_slot0_seen"}, 32'(seen0), 32'd1);
    check({nm, "_slot0_seg"}, 32'(s0), 32'(e0));
    check({nm, "_slot1_seen"}, 32'(seen1), 32'(!b1));
    if (!b1) check({nm, "_slot1_seg"}, 32'(s1), 32'(e1));
    check({nm, "_slot2_seen"}, 32'(seen2), 32'(!b2));
    if (!b2) check({nm, "_slot2_seg"}, 32'(s2), 32'(e2));
  endtask

  task automatic count_busy(input string nm, input int expected);
    int n = 0;
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 40) begin
      n++;
      guard++;
      @(negedge clk);
    end
    check(nm, 32'(n), 32'(expected));
  endtask

  initial begin
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    #2;
    check("reset_anode", 32'(anode), 32'hFE);
    check("reset_seg", 32'(seg), 32'b1000000);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_dp", 32'(dp), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("zero_no_busy", 32'(busy), 32'd0);

    // Small sum: 20
    set_val(9'h014);
    count_busy("small_busy_len", 10);
    repeat (2) @(negedge clk);
    check_frame("small", 7'b1000000, 7'b0100100, 7'h7F, 1'b0, 1'b1);

    // Max sum: 510
    @(negedge clk);
    set_val(9'h1FE);
    count_busy("max_busy_len", 10);
    repeat (2) @(negedge clk);
    check_frame("max", 7'b1000000, 7'b1111001, 7'b0010010, 1'b0, 1'b0);

    // Mid-conversion change: 20 then 9
    @(negedge clk);
    set_val(9'h014);
    begin
      int n = 0;
      int guard = 0;
      while (n < 4 && guard < 40) begin
        @(negedge clk);
        if (busy) n++;
        guard++;
      end
      check("mid_reached_busy4", 32'(n), 32'd4);
    end
    set_val(9'h009);
    repeat (40) @(negedge clk);
    check_frame("mid", 7'b0010000, 7'h7F, 7'h7F, 1'b1, 1'b1);

    // Reset mid-conversion with 99
    set_val(9'h063);
    begin
      int n = 0;
      int guard = 0;
      while (n < 5 && guard < 40) begin
        @(negedge clk);
        if (busy) n++;
        guard++;
      end
      check("rst_reached_busy5", 32'(n), 32'd5);
    end
    #2 rst = 1'b1;
    #1;
    check("rstmid_anode", 32'(anode), 32'hFE);
    check("rstmid_seg", 32'(seg), 32'b1000000);
    check("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_busy("rst_reconv_busy_len", 10);
    repeat (2) @(negedge clk);
    check_frame("rst99", 7'b0010000, 7'b0010000, 7'h7F, 1'b0, 1'b1);

    // Scan sequence with 123
    set_val(123);
    repeat (30) @(negedge clk);
    begin
      int guard = 0;
      while (anode != 8'hFB && guard < 20) begin @(negedge clk); guard++; end
      while (anode == 8'hFB && guard < 20) begin @(negedge clk); guard++; end
      check("scan_sync", 32'(guard < 20), 32'd1);
      for (int i = 0; i < 12; i++) begin
        logic [7:0] ea;
        logic [6:0] es;
        case (i / 4)
          0: begin ea = 8'hFE; es = 7'b0110000; end
          1: begin ea = 8'hFD; es = 7'b0100100; end
          default: begin ea = 8'hFB; es = 7'b1111001; end
        endcase
        check($sformatf("scan_anode_%0d", i), 32'(anode), 32'(ea));
        check($sformatf("scan_seg_%0d", i), 32'(seg), 32'(es));
        check($sformatf("scan_dp_%0d", i), 32'(dp), 32'd1);
        @(negedge clk);
      end
    end

    // Randomized values and hold times, checked every cycle against the model
    for (int k = 0; k < 40; k++) begin
      set_val(int'($urandom_range(0, 511)));
      repeat ($urandom_range(1, 25)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
